// File: rtl/alien_gfx_pkg.sv
// Shared graphics constants for the alien sprites: bitmap, colours, screen size and drawer state encoding.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package alien_gfx_pkg;

    localparam int ALIEN_W      = 8;
    localparam int ALIEN_H      = 6;
    localparam int GFX_SCREEN_W = 160;
    localparam int GFX_SCREEN_H = 120;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COLOUR_BG     = 3'b000;
    localparam logic [COLOUR_W-1:0] COLOUR_ALIEN  = 3'b010;
    localparam logic [COLOUR_W-1:0] COLOUR_PLAYER = 3'b100;

    // ALIEN_BITMAP[row][col]; bit 'col' of each row literal is screen column
    // col, so the rightmost literal bit is the leftmost pixel.
    typedef logic [ALIEN_H-1:0][ALIEN_W-1:0] alien_bitmap_t;

    localparam alien_bitmap_t ALIEN_BITMAP = {
        8'b1100_0010,   // row 5  .X....XX
        8'b1010_0101,   // row 4  X.X..X.X
        8'b1111_1111,   // row 3  XXXXXXXX
        8'b1101_1011,   // row 2  XX.XX.XX
        8'b0111_1110,   // row 1  .XXXXXX.
        8'b0010_0100    // row 0  ..X..X..
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } drawer_state_t;

endpackage

// File: rtl/alien_sprite_drawer_if.sv
// Control handshake (start/busy/done with position) plus pixel stream towards the VGA adapter.
// Latency: none (wiring only).
// Backpressure: none; the VGA adapter accepts one pixel per cycle, start is ignored while busy.
interface alien_sprite_drawer_if;
    import alien_gfx_pkg::*;

    logic                start;
    logic [X_W-1:0]      x_pos;
    logic [Y_W-1:0]      y_pos;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                plot;

    // Controller / consumer side.
    modport master (
        output start, x_pos, y_pos,
        input  busy, done, vga_x, vga_y, vga_colour, plot
    );

    // Drawer side.
    modport slave (
        input  start, x_pos, y_pos,
        output busy, done, vga_x, vga_y, vga_colour, plot
    );
endinterface

// File: rtl/sprite_scan_counter.sv
// Raster col/row counter over a W x H box; col is the inner loop. Ports: clear, advance, col/row, their next values, last.
// Latency: registered count updates on the clock edge; col_nxt/row_nxt expose the value being loaded combinationally.
// Backpressure: none; holds its position when neither clear nor advance is asserted.
module sprite_scan_counter #(
    parameter  int W  = 8,
    parameter  int H  = 6,
    localparam int CW = (W > 1) ? $clog2(W) : 1,
    localparam int RW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col_nxt,
    output logic [RW-1:0] row_nxt,
    output logic          last
);

    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (clear) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (advance) begin
            if (col == CW'(W - 1)) begin
                col_nxt = '0;
                row_nxt = (row == RW'(H - 1)) ? '0 : row + 1'b1;
            end else begin
                col_nxt = col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    assign last = (col == CW'(W - 1)) && (row == RW'(H - 1));

endmodule

// File: rtl/alien_sprite_drawer.sv
// Erases the previous alien box then draws the bitmap at the new position, one pixel per cycle. Ports: clk, reset_n, bus (slave).
// Latency: pixel 0 is on the registered outputs the cycle after start is accepted; done follows the last pixel by one cycle.
// Backpressure: none; start is accepted only in IDLE and dropped otherwise.
module alien_sprite_drawer
    import alien_gfx_pkg::*;
#(
    parameter int                  SPR_W     = ALIEN_W,
    parameter int                  SPR_H     = ALIEN_H,
    parameter int                  SCREEN_W  = GFX_SCREEN_W,
    parameter int                  SCREEN_H  = GFX_SCREEN_H,
    parameter logic [COLOUR_W-1:0] FG_COLOUR = COLOUR_ALIEN,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_BG
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alien_sprite_drawer_if.slave bus
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    drawer_state_t state, state_nxt;

    logic [X_W-1:0] new_x, prev_x;
    logic [Y_W-1:0] new_y, prev_y;
    logic           prev_valid;

    logic           scan_clear, scan_adv, scan_last;
    logic [CW-1:0]  col, col_nxt;
    logic [RW-1:0]  row, row_nxt;

    logic           latch_new, commit_prev;

    // Next-cycle output values; the output registers load these so the pixel
    // for the scan position being entered is visible in the same cycle.
    logic [X_W-1:0]      base_x;
    logic [Y_W-1:0]      base_y;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                on_screen;
    logic                pix_phase;
    logic                plot_nxt;
    logic [COLOUR_W-1:0] colour_nxt;

    sprite_scan_counter #(
        .W (SPR_W),
        .H (SPR_H)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (scan_clear),
        .advance (scan_adv),
        .col     (col),
        .row     (row),
        .col_nxt (col_nxt),
        .row_nxt (row_nxt),
        .last    (scan_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        scan_clear  = 1'b0;
        scan_adv    = 1'b0;
        latch_new   = 1'b0;
        commit_prev = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    latch_new  = 1'b1;
                    scan_clear = 1'b1;
                    state_nxt  = prev_valid ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE: begin
                if (scan_last) begin
                    scan_clear = 1'b1;
                    state_nxt  = ST_DRAW;
                end else begin
                    scan_adv = 1'b1;
                end
            end
            ST_DRAW: begin
                if (scan_last) begin
                    scan_clear = 1'b1;
                    state_nxt  = ST_DONE;
                end else begin
                    scan_adv = 1'b1;
                end
            end
            ST_DONE: begin
                commit_prev = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pixel for the position being entered. Entering DRAW straight from IDLE
    // takes the base from the port, since new_x/new_y load on that same edge.
    always_comb begin
        base_x = prev_x;
        base_y = prev_y;
        if (state_nxt == ST_DRAW) begin
            base_x = (state == ST_IDLE) ? bus.x_pos : new_x;
            base_y = (state == ST_IDLE) ? bus.y_pos : new_y;
        end
        sum_x      = {1'b0, base_x} + (X_W + 1)'(col_nxt);
        sum_y      = {1'b0, base_y} + (Y_W + 1)'(row_nxt);
        on_screen  = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
        pix_phase  = (state_nxt == ST_ERASE) || (state_nxt == ST_DRAW);
        colour_nxt = (state_nxt == ST_DRAW) ? FG_COLOUR : BG_COLOUR;
        plot_nxt   = 1'b0;
        if (state_nxt == ST_ERASE) begin
            plot_nxt = on_screen;
        end else if (state_nxt == ST_DRAW) begin
            plot_nxt = on_screen && ALIEN_BITMAP[row_nxt][col_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            new_x      <= '0;
            new_y      <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else begin
            if (latch_new) begin
                new_x <= bus.x_pos;
                new_y <= bus.y_pos;
            end
            if (commit_prev) begin
                prev_x     <= new_x;
                prev_y     <= new_y;
                prev_valid <= 1'b1;
            end
        end
    end

    // Coordinates and colour hold their last pixel outside the scan phases.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.plot       <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
        end else begin
            bus.busy <= (state_nxt != ST_IDLE);
            bus.done <= (state_nxt == ST_DONE);
            bus.plot <= plot_nxt;
            if (pix_phase) begin
                bus.vga_x      <= sum_x[X_W-1:0];
                bus.vga_y      <= sum_y[Y_W-1:0];
                bus.vga_colour <= colour_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alien_sprite_drawer.sv
// Directed and randomized frames against a pixel-list reference model of the alien drawer.
// Latency: expects pixel 0 one cycle after the accepting edge and done right after the last pixel.
// Backpressure: exercises ignored starts while busy and back-to-back starts.
module tb_alien_sprite_drawer;

    logic clk;
    logic reset_n;

    alien_sprite_drawer_if bus ();

    alien_sprite_drawer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] c;
        logic       p;
    } px_t;

    string sprite_art [6] = '{
        "..X..X..",
        ".XXXXXX.",
        "XX.XX.XX",
        "XXXXXXXX",
        "X.X..X.X",
        ".X....XX"
    };

    int checks   = 0;
    int failures = 0;

    bit m_prev_valid = 1'b0;
    int m_prev_x     = 0;
    int m_prev_y     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observed_all();
        return {11'd0, bus.busy, bus.done, bus.plot, bus.vga_x, bus.vga_y, bus.vga_colour};
    endfunction

    // Appends one 8x6 box: screen coordinates wrap modulo the port widths,
    // anything off the 160x120 screen is never plotted.
    task automatic add_box(inout px_t q[$], input int bx, input int by, input bit draw);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                px_t e;
                int sx = bx + c;
                int sy = by + r;
                bit vis = (sx < 160) && (sy < 120);
                e.x = sx % 256;
                e.y = sy % 128;
                e.c = draw ? 3'b010 : 3'b000;
                e.p = draw ? (vis && (sprite_art[r][c] == "X")) : vis;
                q.push_back(e);
            end
        end
    endtask

    // Call at a negedge while the DUT is idle; returns at the negedge of the
    // idle cycle after done, so a back-to-back start can follow immediately.
    task automatic run_frame(input int nx, input int ny, input int inj, input int abort_at);
        px_t q[$];
        if (m_prev_valid) add_box(q, m_prev_x, m_prev_y, 1'b0);
        add_box(q, nx, ny, 1'b1);
        bus.start = 1'b1;
        bus.x_pos = 8'(nx);
        bus.y_pos = 7'(ny);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            check("pixel", observed_all(),
                  {11'd0, 1'b1, 1'b0, q[i].p, 8'(q[i].x), 7'(q[i].y), q[i].c});
            if (i == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                check("abort_reset", observed_all(), 32'd0);
                reset_n      = 1'b1;
                m_prev_valid = 1'b0;
                @(negedge clk);
                check("abort_idle", {29'd0, bus.busy, bus.done, bus.plot}, 32'd0);
                return;
            end
            if (i == inj) begin
                bus.start = 1'b1;
                bus.x_pos = 8'd50;
                bus.y_pos = 7'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done", {29'd0, bus.busy, bus.done, bus.plot}, 32'b110);
        m_prev_valid = 1'b1;
        m_prev_x     = nx;
        m_prev_y     = ny;
        @(negedge clk);
        check("idle", {29'd0, bus.busy, bus.done, bus.plot}, 32'b000);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x_pos = '0;
        bus.y_pos = '0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", observed_all(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {29'd0, bus.busy, bus.done, bus.plot}, 32'd0);

        // First frame: draw only. Second frame: erase then draw.
        run_frame(10, 20, -1, -1);
        @(negedge clk);
        run_frame(12, 20, -1, -1);
        @(negedge clk);

        // Right/bottom edge clipping.
        run_frame(156, 114, -1, -1);
        @(negedge clk);
        run_frame(40, 30, -1, -1);

        // A start pulse in the middle of the erase is dropped.
        run_frame(70, 40, 5, -1);
        repeat (4) begin
            check("no_extra_done", {29'd0, bus.busy, bus.done}, 32'd0);
            @(negedge clk);
        end
        run_frame(20, 50, -1, -1);
        @(negedge clk);

        // Reset at DRAW pixel 20 (after the 48 erase pixels), then draw-only.
        run_frame(60, 60, -1, 48 + 20);
        run_frame(30, 10, -1, -1);

        // Back-to-back start on the first idle cycle after done.
        run_frame(90, 90, -1, -1);

        // Randomized positions, gaps and a few busy-time starts.
        for (int n = 0; n < 10; n++) begin
            int rx  = int'($urandom_range(0, 255));
            int ry  = int'($urandom_range(0, 127));
            int inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_frame(rx, ry, inj, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alien_sprite_drawer.md
# alien_sprite_drawer

Renders one alien sprite into the VGA adapter's frame buffer. It sits downstream of each `alien` position block: it consumes the alien's `x_pos`/`y_pos` and emits a pixel stream (`vga_x`, `vga_y`, `vga_colour`, `plot`) to the 160x120 VGA adapter. Each draw request first erases the sprite box at the previously drawn position, then draws the bitmap at the new position. The game controller sequences it with a start/busy/done handshake.

## Interface

**Parameters**
- `SPR_W`, default 8: sprite width in pixels.
- `SPR_H`, default 6: sprite height in pixels.
- `SCREEN_W`, default 160: horizontal screen size; used for clipping.
- `SCREEN_H`, default 120: vertical screen size; used for clipping.
- `FG_COLOUR`, default 3'b010: alien colour.
- `BG_COLOUR`, default 3'b000: erase colour.

**Ports**
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, synchronous, active-low. Sampled on the rising edge of `clk`.
- `start`, in, 1: draw request. Accepted only in IDLE.
- `x_pos`, in, 8: new sprite top-left x. Sampled on the accepted `start`.
- `y_pos`, in, 7: new sprite top-left y. Sampled on the accepted `start`.
- `busy`, out, 1: high from the cycle after an accepted start through the DONE cycle.
- `done`, out, 1: one-cycle pulse when the frame update completes.
- `vga_x`, out, 8: pixel x coordinate.
- `vga_y`, out, 7: pixel y coordinate.
- `vga_colour`, out, 3: pixel colour.
- `plot`, out, 1: write-enable for the current pixel.

## Operation

- **States:** IDLE, ERASE, DRAW, DONE.
- **IDLE + start:**
  - Latch `new_x`/`new_y` from `x_pos`/`y_pos`.
  - If `prev_valid`=1, go to ERASE; otherwise go to DRAW.
- **Scan order:** raster-scan the box one pixel per cycle. `col` runs 0..SPR_W-1 (inner loop), `row` runs 0..SPR_H-1 (outer loop). The scan counter resets at the start of each state.
- **ERASE:** every pixel at `prev + (col,row)` is output with `vga_colour`=BG_COLOUR. After the last pixel, go to DRAW.
- **DRAW:** every pixel at `new + (col,row)` is output with `vga_colour`=FG_COLOUR. `plot`=1 only where `ALIEN_BITMAP[row][col]`=1; the sprite is transparent elsewhere. After the last pixel, go to DONE.
- **DONE:**
  - `done`=1 for this one cycle.
  - `prev_x`/`prev_y` <= `new_x`/`new_y`, and `prev_valid` <= 1.
  - Go to IDLE.
- **Arithmetic and clipping:**
  - x is computed as a 9-bit sum and y as an 8-bit sum.
  - A pixel with sum_x >= SCREEN_W or sum_y >= SCREEN_H has `plot` forced to 0.
  - `vga_x`/`vga_y` carry the truncated sum.
- **Start while not IDLE:** ignored, and not queued. Changes on `x_pos`/`y_pos` while busy have no effect.
- **Reset (including mid-operation):**
  - State returns to IDLE; `prev_valid`=0; scan counters are cleared.
  - `plot`=0, `busy`=0, `done`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
  - No `done` is issued for the aborted frame.

## Timing

- All outputs are registered.
- A start accepted at edge k puts pixel 0 on the outputs during cycle k+1. Pixel i appears in cycle k+1+i.
- N = SPR_W*SPR_H pixels per phase (48 at the defaults).
- With erase: ERASE occupies cycles k+1..k+N, DRAW occupies cycles k+N+1..k+2N, and `done` is high in cycle k+2N+1.
- Without erase (first frame after reset): DRAW occupies cycles k+1..k+N, and `done` is high in cycle k+N+1.
- The earliest next accepted start is the edge ending the cycle after DONE (IDLE).
- The bitmap lookup is combinational from a constant, so the pixel stream has no bubbles.

## Structure

- Shared package `alien_gfx_pkg` holds:
  - the `ALIEN_BITMAP` constant (SPR_H x SPR_W bits);
  - colour constants (BG, ALIEN, PLAYER);
  - SCREEN_W/SCREEN_H constants;
  - the drawer state enum.
- Sub-module `sprite_scan_counter` holds the col/row counters with `clear`, `advance`, and a `last` flag (asserted when col=SPR_W-1 and row=SPR_H-1). ERASE and DRAW reuse the same instance.

## Test plan

- **First frame:** reset, then start with x=10, y=20.
  - No BG pixels are emitted.
  - 48 DRAW cycles cover x 10..17, y 20..25; `plot` matches the bitmap exactly.
  - `done` pulses at cycle 49.
- **Second frame:** start with x=12, y=20.
  - 48 BG pixels with `plot`=1 cover x 10..17, y 20..25.
  - Then the bitmap is drawn at x 12..19.
  - `done` pulses at cycle 97, and `busy` is high for cycles 1..97.
- **Right-edge clipping:** start with x=156, y=114.
  - Columns 160..163 have `plot`=0.
  - Rows up to 119 are plotted and none at or beyond 120; no output wraps to x<8.
- **Start while busy:** pulse `start` with x=50 while busy.
  - The pulse is ignored and no second `done` follows.
  - The next erase uses the originally latched position.
- **Reset mid-DRAW:** assert reset at pixel 20.
  - `plot`, `busy`, `done` are 0 next cycle.
  - The following start at x=30 produces DRAW only (no erase), with `done` at N+1.
- **Back-to-back:** start on the first IDLE cycle after DONE.
  - It is accepted, and the erase covers the just-drawn box.
